// File: rtl/spike_pushback_fifo_if.sv
// Valid/ready pop port of the spike pushback FIFO. The FIFO drives it through
// the master modport and the host-side event reader through the slave modport.
interface spike_pushback_fifo_if #(
    parameter int AW     = 8,
    parameter int TICK_W = 8
);
    logic              pop_valid_o;
    logic              pop_ready_i;
    logic [AW-1:0]     pop_addr_o;
    logic [TICK_W-1:0] pop_tick_o;

    modport master (
        output pop_valid_o,
        output pop_addr_o,
        output pop_tick_o,
        input  pop_ready_i
    );

    modport slave (
        input  pop_valid_o,
        input  pop_addr_o,
        input  pop_tick_o,
        output pop_ready_i
    );
endinterface

// File: rtl/spike_pushback_fifo.sv
// Buffers tinyODIN output-layer spikes for the host. Inference ends on a spike
// count target or a tick timeout, and the done flag waits until the FIFO drains.
module spike_pushback_fifo #(
    parameter  int N      = 256,
    parameter  int DEPTH  = 16,
    parameter  int TICK_W = 8,
    localparam int AW     = $clog2(N),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   spike_i,
    input  logic [AW-1:0]          count_i,
    input  logic [TICK_W-1:0]      tick_i,
    input  logic [AW-1:0]          out_base_i,
    input  logic [7:0]             spike_target_i,
    spike_pushback_fifo_if.master  pop_if,
    output logic [CW-1:0]          fifo_count_o,
    output logic                   overflow_o,
    output logic                   inference_done_o,
    output logic [1:0]             done_cause_o
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q,    state_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [7:0]    spk_cnt_q,  spk_cnt_d;
    logic          overflow_q, overflow_d;
    logic [1:0]    cause_q,    cause_d;
    logic          done_q,     done_d;

    logic [AW-1:0]     addr_mem_q [DEPTH];
    logic [TICK_W-1:0] tick_mem_q [DEPTH];

    logic       pop_valid;
    logic       full;
    logic       out_spike;
    logic       pop;
    logic       push;
    logic [7:0] spk_inc;
    logic       target_hit;
    logic       timeout_hit;

    assign pop_valid = (cnt_q != '0);
    assign full      = (cnt_q == CW'(DEPTH));

    // start_i wins over everything in its cycle: the spike and the pop are both lost.
    assign out_spike   = (state_q == S_RUN) && spike_i && (count_i >= out_base_i) && !start_i;
    assign pop         = pop_valid && pop_if.pop_ready_i && !start_i;
    assign push        = out_spike && (!full || pop);
    assign spk_inc     = (spk_cnt_q == 8'hFF) ? 8'hFF : spk_cnt_q + 8'd1;
    assign target_hit  = out_spike && (spike_target_i != 8'd0) && (spk_inc == spike_target_i);
    assign timeout_hit = (state_q == S_RUN) && (tick_i == TICK_W'(1));

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        spk_cnt_d  = spk_cnt_q;
        overflow_d = overflow_q;
        cause_d    = cause_q;

        if (start_i) begin
            state_d    = S_RUN;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            spk_cnt_d  = 8'd0;
            overflow_d = 1'b0;
            cause_d    = 2'b00;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            if (out_spike)          spk_cnt_d  = spk_inc;
            if (out_spike && !push) overflow_d = 1'b1;

            case (state_q)
                S_RUN: begin
                    if (target_hit || timeout_hit) begin
                        state_d = S_DRAIN;
                        cause_d = {timeout_hit, target_hit};
                    end
                end
                S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            spk_cnt_q  <= 8'd0;
            overflow_q <= 1'b0;
            cause_q    <= 2'b00;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            spk_cnt_q  <= spk_cnt_d;
            overflow_q <= overflow_d;
            cause_q    <= cause_d;
            done_q     <= done_d;
        end
    end

    // NOTE: storage is not reset; the head outputs are masked while empty instead.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= count_i;
            tick_mem_q[wr_ptr_q] <= tick_i;
        end
    end

    assign pop_if.pop_valid_o = pop_valid;
    assign pop_if.pop_addr_o  = pop_valid ? addr_mem_q[rd_ptr_q] : '0;
    assign pop_if.pop_tick_o  = pop_valid ? tick_mem_q[rd_ptr_q] : '0;
    assign fifo_count_o       = cnt_q;
    assign overflow_o         = overflow_q;
    assign inference_done_o   = done_q;
    assign done_cause_o       = cause_q;
endmodule

// File: tb/tb_spike_pushback_fifo.sv
// Directed bench for spike_pushback_fifo: target end, timeout end, overflow,
// full-with-pop, both causes, restart during drain and reset during drain.
module tb_spike_pushback_fifo;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       spike_i = 1'b0;
    logic [7:0] count_i = 8'd0;
    logic [7:0] tick_i = 8'd100;
    logic [7:0] out_base_i = 8'd200;
    logic [7:0] spike_target_i = 8'd0;
    logic [4:0] fifo_count_o;
    logic       overflow_o;
    logic       inference_done_o;
    logic [1:0] done_cause_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    spike_pushback_fifo_if #(.AW(8), .TICK_W(8)) pop_if ();

    spike_pushback_fifo #(.N(256), .DEPTH(16), .TICK_W(8)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .spike_i          (spike_i),
        .count_i          (count_i),
        .tick_i           (tick_i),
        .out_base_i       (out_base_i),
        .spike_target_i   (spike_target_i),
        .pop_if           (pop_if.master),
        .fifo_count_o     (fifo_count_o),
        .overflow_o       (overflow_o),
        .inference_done_o (inference_done_o),
        .done_cause_o     (done_cause_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic spike(input logic [7:0] addr, input logic [7:0] tick);
        spike_i = 1'b1;
        count_i = addr;
        tick_i  = tick;
        cyc();
        spike_i = 1'b0;
        tick_i  = 8'd100;
    endtask

    initial begin
        pop_if.pop_ready_i = 1'b0;

        // Reset values
        repeat (2) cyc();
        check("rst_valid", pop_if.pop_valid_o, 0);
        check("rst_addr", pop_if.pop_addr_o, 0);
        check("rst_tick", pop_if.pop_tick_o, 0);
        check("rst_count", fifo_count_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_done", inference_done_o, 0);
        check("rst_cause", done_cause_o, 0);
        check("rst_state", dut.state_q, S_IDLE);
        rst_i = 1'b0;
        spike(8'd230, 8'd100);
        check("idle_no_capture", fifo_count_o, 0);

        // Target end
        out_base_i = 8'd200;
        spike_target_i = 8'd3;
        pop_if.pop_ready_i = 1'b1;
        do_start();
        spike(8'd210, 8'd100);
        check("tgt_head0", pop_if.pop_addr_o, 210);
        spike(8'd199, 8'd100);
        check("tgt_199_absent", pop_if.pop_valid_o, 0);
        spike(8'd220, 8'd100);
        check("tgt_head1", pop_if.pop_addr_o, 220);
        spike(8'd230, 8'd100);
        check("tgt_head2", pop_if.pop_addr_o, 230);
        check("tgt_state_drain", dut.state_q, S_DRAIN);
        check("tgt_cause", done_cause_o, 1);
        check("tgt_done_lo0", inference_done_o, 0);
        cyc();
        check("tgt_empty", fifo_count_o, 0);
        check("tgt_done_lo1", inference_done_o, 0);
        cyc();
        check("tgt_done_hi", inference_done_o, 1);
        spike(8'd240, 8'd1);
        check("done_ignores_spike", fifo_count_o, 0);
        check("done_holds", inference_done_o, 1);

        // Timeout end
        spike_target_i = 8'd0;
        pop_if.pop_ready_i = 1'b0;
        do_start();
        check("to_start_clr_done", inference_done_o, 0);
        check("to_start_clr_cause", done_cause_o, 0);
        spike(8'd240, 8'd5);
        tick_i = 8'd4; cyc();
        tick_i = 8'd3; cyc();
        tick_i = 8'd2; cyc();
        check("to_still_run", dut.state_q, S_RUN);
        tick_i = 8'd1; cyc();
        tick_i = 8'd100;
        check("to_state_drain", dut.state_q, S_DRAIN);
        check("to_cause", done_cause_o, 2);
        check("to_head_addr", pop_if.pop_addr_o, 240);
        check("to_head_tick", pop_if.pop_tick_o, 5);
        pop_if.pop_ready_i = 1'b1;
        cyc();
        check("to_done_lo", inference_done_o, 0);
        check("to_empty", fifo_count_o, 0);
        cyc();
        check("to_done_hi", inference_done_o, 1);

        // Overflow
        pop_if.pop_ready_i = 1'b0;
        do_start();
        for (int i = 0; i < 18; i++) spike(8'(200 + i), 8'(50 + i));
        check("ovf_count", fifo_count_o, 16);
        check("ovf_flag", overflow_o, 1);
        pop_if.pop_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf_addr%0d", i), pop_if.pop_addr_o, 200 + i);
            check($sformatf("ovf_tick%0d", i), pop_if.pop_tick_o, 50 + i);
            cyc();
        end
        check("ovf_drained", fifo_count_o, 0);

        // Full plus simultaneous pop
        pop_if.pop_ready_i = 1'b0;
        do_start();
        check("full_start_clr_ovf", overflow_o, 0);
        for (int i = 0; i < 16; i++) spike(8'(200 + i), 8'(60 + i));
        check("full_count", fifo_count_o, 16);
        check("full_hold_addr", pop_if.pop_addr_o, 200);
        pop_if.pop_ready_i = 1'b1;
        spike(8'd250, 8'd77);
        check("fp_count", fifo_count_o, 16);
        check("fp_ovf", overflow_o, 0);
        check("fp_head", pop_if.pop_addr_o, 201);
        repeat (15) cyc();
        check("fp_tail_addr", pop_if.pop_addr_o, 250);
        check("fp_tail_tick", pop_if.pop_tick_o, 77);
        cyc();
        check("fp_empty", fifo_count_o, 0);

        // Both causes
        spike_target_i = 8'd2;
        do_start();
        spike(8'd210, 8'd100);
        spike(8'd211, 8'd1);
        check("both_cause", done_cause_o, 3);
        check("both_state", dut.state_q, S_DRAIN);
        repeat (2) cyc();
        check("both_done", inference_done_o, 1);

        // Restart during DRAIN with 5 pending
        spike_target_i = 8'd0;
        pop_if.pop_ready_i = 1'b0;
        do_start();
        for (int i = 0; i < 17; i++) spike(8'(200 + i), 8'd100);
        pop_if.pop_ready_i = 1'b1;
        repeat (11) cyc();
        pop_if.pop_ready_i = 1'b0;
        tick_i = 8'd1; cyc();
        tick_i = 8'd100;
        check("rs_pre_state", dut.state_q, S_DRAIN);
        check("rs_pre_count", fifo_count_o, 5);
        check("rs_pre_ovf", overflow_o, 1);
        check("rs_pre_cause", done_cause_o, 2);
        start_i = 1'b1;
        spike_i = 1'b1;
        count_i = 8'd222;
        pop_if.pop_ready_i = 1'b1;
        cyc();
        start_i = 1'b0;
        spike_i = 1'b0;
        pop_if.pop_ready_i = 1'b0;
        check("rs_count", fifo_count_o, 0);
        check("rs_valid", pop_if.pop_valid_o, 0);
        check("rs_ovf", overflow_o, 0);
        check("rs_cause", done_cause_o, 0);
        check("rs_state", dut.state_q, S_RUN);
        check("rs_done", inference_done_o, 0);
        spike(8'd223, 8'd100);
        check("rs_capture_count", fifo_count_o, 1);
        check("rs_capture_addr", pop_if.pop_addr_o, 223);

        // Asynchronous reset mid-DRAIN
        tick_i = 8'd1; cyc();
        tick_i = 8'd100;
        check("ar_state_drain", dut.state_q, S_DRAIN);
        rst_i = 1'b1;
        #2;
        check("ar_count", fifo_count_o, 0);
        check("ar_valid", pop_if.pop_valid_o, 0);
        check("ar_state", dut.state_q, S_IDLE);
        rst_i = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
